// File: rtl/ram_copy_master.sv
// Avalon-MM master that copies a word range or fills it with a constant.
// One request in flight at a time: every read completes before its write issues.
module ram_copy_master #(
  parameter int ADDR_W = 14,
  parameter int LEN_W  = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic [31:0]       fill_data,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  words_done,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid
);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, FINISH} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] src_ptr, dst_ptr;
  logic [LEN_W-1:0]  len_q, words_q;
  logic              fill_q;
  logic [31:0]       wdata_q;
  logic              wr_accept, last_word;

  assign wr_accept = (state == WR_REQ) && !avm_waitrequest;
  assign last_word = (words_q + LEN_W'(1)) == len_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (length == '0) state_nxt = FINISH;
          else if (mode)    state_nxt = WR_REQ;
          else              state_nxt = RD_REQ;
        end
      end
      RD_REQ:  if (!avm_waitrequest)  state_nxt = RD_WAIT;
      RD_WAIT: if (avm_readdatavalid) state_nxt = WR_REQ;
      WR_REQ: begin
        if (!avm_waitrequest) begin
          if (last_word)   state_nxt = FINISH;
          else if (fill_q) state_nxt = WR_REQ;
          else             state_nxt = RD_REQ;
        end
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pointers wrap modulo 2^ADDR_W by plain truncating addition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_ptr <= '0;
      dst_ptr <= '0;
      len_q   <= '0;
      words_q <= '0;
      fill_q  <= 1'b0;
      wdata_q <= '0;
    end else begin
      if (state == IDLE && start) begin
        src_ptr <= src_addr & ~ADDR_W'(3);
        dst_ptr <= dst_addr & ~ADDR_W'(3);
        len_q   <= length;
        words_q <= '0;
        fill_q  <= mode;
        if (mode) wdata_q <= fill_data;
      end
      if (state == RD_WAIT && avm_readdatavalid) wdata_q <= avm_readdata;
      if (wr_accept) begin
        words_q <= words_q + LEN_W'(1);
        dst_ptr <= dst_ptr + ADDR_W'(4);
        if (!fill_q) src_ptr <= src_ptr + ADDR_W'(4);
      end
    end
  end

  // Requests decode straight from the state so reset drops them asynchronously.
  always_comb begin
    avm_read       = (state == RD_REQ);
    avm_write      = (state == WR_REQ);
    avm_address    = '0;
    if (avm_read)  avm_address = src_ptr;
    if (avm_write) avm_address = dst_ptr;
    avm_byteenable = (avm_read || avm_write) ? '1 : '0;
    avm_writedata  = wdata_q;
    busy           = (state == RD_REQ) || (state == RD_WAIT) || (state == WR_REQ);
    done           = (state == FINISH);
    words_done     = words_q;
  end

endmodule

// File: tb/tb_ram_copy_master.sv
// Bench for ram_copy_master: RAM slave with configurable stalls and read latency,
// an expected-write queue built from command arithmetic, and per-cycle checks.
module tb_ram_copy_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, mode;
  logic [13:0] src_addr, dst_addr;
  logic [12:0] length;
  logic [31:0] fill_data;
  logic        busy, done;
  logic [12:0] words_done;
  logic [13:0] avm_address;
  logic        avm_read, avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;

  int n_checks = 0;
  int n_fail   = 0;

  ram_copy_master #(.ADDR_W(14), .LEN_W(13)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length), .fill_data(fill_data),
    .busy(busy), .done(done), .words_done(words_done),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid)
  );

  always #5 clk = ~clk;

  // RAM slave model
  logic [31:0] mem [0:4095];
  int          rd_lat = 1, rd_stall = 0, wr_stall = 0;
  int          wcnt = 0, pend_cnt = 0;
  logic [31:0] pend_data = '0;

  assign avm_waitrequest   = (avm_read && wcnt < rd_stall) || (avm_write && wcnt < wr_stall);
  assign avm_readdatavalid = (pend_cnt == 1);
  assign avm_readdata      = pend_data;

  always @(posedge clk) begin
    if ((avm_read || avm_write) && avm_waitrequest) wcnt <= wcnt + 1;
    else                                            wcnt <= 0;
    if (avm_read && !avm_waitrequest) begin
      pend_data <= mem[avm_address[13:2]];
      pend_cnt  <= rd_lat;
    end else if (pend_cnt > 0) begin
      pend_cnt <= pend_cnt - 1;
    end
    if (avm_write && !avm_waitrequest) mem[avm_address[13:2]] <= avm_writedata;
  end

  typedef struct {
    logic [13:0] a;
    logic [31:0] d;
  } wr_t;
  wr_t exp_q[$];
  int  wr_seen = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle compare against the expected write stream and bus rules.
  initial begin : compare
    logic        prev_stall;
    logic [47:0] prev_vec;
    wr_t         e;
    prev_stall = 1'b0;
    prev_vec   = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        chk("rd_wr_exclusive", 64'(avm_read && avm_write), 64'd0);
        chk("byteenable", 64'(avm_byteenable), (avm_read || avm_write) ? 64'hF : 64'h0);
        if (done) chk("done_no_busy", {61'd0, busy, avm_read, avm_write}, 64'd0);
        if (prev_stall)
          chk("stall_hold", 64'({avm_read, avm_write, avm_address, avm_writedata}), 64'(prev_vec));
        if (busy || done) chk("words_done_track", 64'(words_done), 64'(wr_seen));
        if (avm_write && !avm_waitrequest) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_write", 64'(avm_address), 64'h3FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("wr_addr", 64'(avm_address), 64'(e.a));
            chk("wr_data", 64'(avm_writedata), 64'(e.d));
          end
          wr_seen++;
        end
        prev_stall = (avm_read || avm_write) && avm_waitrequest;
        prev_vec   = {avm_read, avm_write, avm_address, avm_writedata};
      end
    end
  end

  task automatic build_exp(input logic m, input logic [13:0] s, input logic [13:0] d,
                           input logic [12:0] len, input logic [31:0] f);
    logic [13:0] sa, da;
    wr_t         w;
    exp_q.delete();
    for (int i = 0; i < int'(len); i++) begin
      sa  = (s & 14'h3FFC) + 14'(4 * i);
      da  = (d & 14'h3FFC) + 14'(4 * i);
      w.a = da;
      w.d = m ? f : mem[sa[13:2]];
      exp_q.push_back(w);
    end
    wr_seen = 0;
  endtask

  task automatic run_cmd(input logic m, input logic [13:0] s, input logic [13:0] d,
                         input logic [12:0] len, input logic [31:0] f,
                         input int lat, input int rs, input int ws,
                         input int exp_cyc, input bit restart);
    int cyc;
    rd_lat = lat; rd_stall = rs; wr_stall = ws;
    build_exp(m, s, d, len, f);
    @(negedge clk);
    mode = m; src_addr = s; dst_addr = d; length = len; fill_data = f; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    chk("busy_after_start", 64'(busy), 64'(len != 0));
    while (!done && cyc < 2000) begin
      if (restart && cyc == 2) begin
        start = 1'b1; dst_addr = 14'h0800; length = 13'd1; mode = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    chk("done_cycle", 64'(cyc), 64'(exp_cyc));
    chk("final_words_done", 64'(words_done), 64'(len));
    chk("all_writes_seen", 64'(exp_q.size()), 64'd0);
    // start during the FINISH pulse must be dropped
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("start_in_finish_ignored", {61'd0, busy, avm_read, avm_write}, 64'd0);
    chk("words_done_hold", 64'(words_done), 64'(len));
  endtask

  initial begin : stim
    int cyc, rdv_seen;
    reset = 1'b1; start = 1'b0; mode = 1'b0;
    src_addr = '0; dst_addr = '0; length = '0; fill_data = '0;
    for (int i = 0; i < 4096; i++) mem[i] <= 32'h0;
    #1;
    mem[0] <= 32'd1; mem[1] <= 32'd2; mem[2] <= 32'd3; mem[3] <= 32'd4;
    mem[16] <= 32'h11; mem[17] <= 32'h22; mem[18] <= 32'h33; mem[19] <= 32'h44;
    mem[12'h200] <= 32'hDEAD0000;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({busy, done, avm_read, avm_write, avm_byteenable, avm_address}), 64'd0);
    chk("reset_wdata_count", 64'({avm_writedata, words_done}), 64'd0);
    reset = 1'b0;

    // copy 4 words, latency 1: 3 cycles per word + FINISH
    run_cmd(1'b0, 14'h0000, 14'h0200, 13'd4, 32'h0, 1, 0, 0, 13, 1'b0);
    chk("copy_mem0", 64'(mem[12'h080]), 64'd1);
    chk("copy_mem3", 64'(mem[12'h083]), 64'd4);

    // copy under stalls: per word 3 read + 1 wait + 4 write cycles
    run_cmd(1'b0, 14'h0001, 14'h0302, 13'd3, 32'h0, 1, 2, 3, 25, 1'b0);
    chk("stall_copy_mem2", 64'(mem[12'h0C2]), 64'd3);

    // fill 4 words back-to-back
    run_cmd(1'b1, 14'h0000, 14'h0100, 13'd4, 32'hA5A5_5A5A, 1, 0, 0, 5, 1'b0);
    chk("fill_mem0", 64'(mem[12'h040]), 64'hA5A5_5A5A);
    chk("fill_mem3", 64'(mem[12'h043]), 64'hA5A5_5A5A);

    // zero length: FINISH directly, no bus activity
    run_cmd(1'b0, 14'h0000, 14'h0400, 13'd0, 32'h0, 1, 0, 0, 1, 1'b0);

    // fill across the top of the address space
    run_cmd(1'b1, 14'h0000, 14'h3FF8, 13'd4, 32'hCAFE_0001, 1, 0, 0, 5, 1'b0);
    chk("wrap_mem_3ffc", 64'(mem[12'hFFF]), 64'hCAFE_0001);
    chk("wrap_mem_0004", 64'(mem[12'h001]), 64'hCAFE_0001);

    // second start while busy is ignored
    run_cmd(1'b1, 14'h0000, 14'h0500, 13'd4, 32'h5555_AAAA, 1, 0, 0, 5, 1'b1);
    chk("restart_untouched", 64'(mem[12'h200]), 64'hDEAD0000);

    // reset during the third read of a copy, with read data still pending
    rd_lat = 3; rd_stall = 0; wr_stall = 0;
    build_exp(1'b0, 14'h0040, 14'h0600, 13'd4, 32'h0);
    @(negedge clk);
    mode = 1'b0; src_addr = 14'h0040; dst_addr = 14'h0600; length = 13'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(words_done == 13'd2 && busy && !avm_read && !avm_write) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("reach_third_read", 64'(cyc < 200), 64'd1);
    #1 reset = 1'b1;
    exp_q.delete();
    #1;
    chk("abort_outputs", 64'({busy, done, avm_read, avm_write, avm_byteenable, avm_address}), 64'd0);
    chk("abort_count", 64'(words_done), 64'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    rdv_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (avm_readdatavalid) rdv_seen++;
      chk("late_rdv_idle", {60'd0, busy, done, avm_read, avm_write}, 64'd0);
    end
    chk("late_rdv_occurred", 64'(rdv_seen), 64'd1);
    chk("abort_partial_mem", 64'(mem[12'h181]), 64'h22);
    chk("abort_no_third", 64'(mem[12'h182]), 64'd0);

    run_cmd(1'b1, 14'h0000, 14'h0700, 13'd2, 32'h1234_5678, 1, 0, 0, 3, 1'b0);
    chk("post_reset_fill", 64'(mem[12'h1C1]), 64'h1234_5678);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
